addr_seq_ctrl: RTL

//  Next-generation fetch/data address-mode sequencer for the 16-bit core. Drives the select of
//  the PC/branch/data address mux from the instruction in EX. Adds multi-word LDM/STM transfers,
//  a memory-ready wait handshake, a parametrised data hold time and deferred branch redirection.

---
 rtl/addr_seq_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/addr_seq_ctrl.sv
// rtl/addr_seq_ctrl.sv - fetch/data address-mode sequencer with LDM/STM transfers
// Selects PC/branch/data address source from the instruction in EX; outputs decode combinationally.
module addr_seq_ctrl #(
  parameter int         IR_W      = 16,
  parameter int         LIST_W    = 8,
  parameter int         DATA_HOLD = 1,
  parameter logic [4:0] OP_STR    = 5'b01100,
  parameter logic [4:0] OP_LDR    = 5'b01101,
  parameter logic [4:0] OP_STM    = 5'b11000,
  parameter logic [4:0] OP_LDM    = 5'b11001
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_branch_met,
  input  logic [IR_W-1:0]              i_ir_ex,
  input  logic                         i_mem_ready,
  output logic [1:0]                   o_addr_mode,
  output logic                         o_stall,
  output logic [$clog2(LIST_W+1)-1:0]  o_xfer_idx,
  output logic                         o_xfer_last
);

  localparam int IDX_W  = $clog2(LIST_W + 1);
  localparam int HOLD_W = (DATA_HOLD > 1) ? $clog2(DATA_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'((DATA_HOLD > 0) ? DATA_HOLD - 1 : 0);
  localparam bit HOLD_EN = (DATA_HOLD > 0);

  localparam logic [1:0] MODE_NORMAL   = 2'd0;
  localparam logic [1:0] MODE_ALU_IR   = 2'd1;
  localparam logic [1:0] MODE_MEM      = 2'd2;
  localparam logic [1:0] MODE_ALU_DATA = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_BR, S_HOLD} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  n_reg;
  logic              pend;
  logic [HOLD_W-1:0] hold_rem;

  logic [4:0]       opcode;
  logic             is_multi;
  logic             is_data;
  logic [IDX_W-1:0] pop;
  logic [IDX_W-1:0] n_dec;
  logic             decode;
  logic             present;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] cur_n;
  logic             last;
  logic             final_done;
  logic             unused_ir;

  assign unused_ir = ^i_ir_ex;
  assign opcode    = i_ir_ex[IR_W-1:IR_W-5];
  assign is_multi  = (opcode == OP_STM) || (opcode == OP_LDM);
  assign is_data   = is_multi || (opcode == OP_STR) || (opcode == OP_LDR);

  always_comb begin
    pop = '0;
    for (int i = 0; i < LIST_W; i++) begin
      pop = pop + IDX_W'(i_ir_ex[i]);
    end
  end

  // An empty register list still performs one transfer.
  assign n_dec = (is_multi && (pop != '0)) ? pop : IDX_W'(1);

  always_comb begin
    decode  = 1'b0;
    present = 1'b0;
    cur_idx = '0;
    cur_n   = n_reg;
    case (state)
      S_IDLE, S_HOLD: begin
        if (!i_branch_met && is_data) begin
          decode  = 1'b1;
          present = 1'b1;
          cur_n   = n_dec;
        end
      end
      S_DATA: begin
        present = 1'b1;
        cur_idx = idx;
      end
      default: ;
    endcase
  end

  assign last       = present && (cur_idx == cur_n - IDX_W'(1));
  assign final_done = last && i_mem_ready;

  always_comb begin
    o_addr_mode = MODE_NORMAL;
    o_stall     = 1'b0;
    o_xfer_idx  = '0;
    o_xfer_last = 1'b0;
    if (rst) begin
      if (present) begin
        o_addr_mode = i_mem_ready ? MODE_ALU_DATA : MODE_MEM;
        o_stall     = !final_done;
        o_xfer_idx  = cur_idx;
        o_xfer_last = last;
      end else if ((state == S_BR) ||
                   (((state == S_IDLE) || (state == S_HOLD)) && i_branch_met)) begin
        o_addr_mode = MODE_ALU_IR;
      end else if (state == S_HOLD) begin
        o_addr_mode = MODE_ALU_DATA;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      n_reg    <= '0;
      pend     <= 1'b0;
      hold_rem <= '0;
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (i_branch_met) begin
            state <= S_IDLE;
            pend  <= 1'b0;
          end else if (decode) begin
            n_reg <= n_dec;
            pend  <= 1'b0;
            if (final_done) begin
              idx      <= '0;
              state    <= HOLD_EN ? S_HOLD : S_IDLE;
              hold_rem <= HOLD_INIT;
            end else begin
              idx   <= i_mem_ready ? IDX_W'(1) : '0;
              state <= S_DATA;
            end
          end else if (state == S_HOLD) begin
            if (hold_rem == '0) begin
              state <= S_IDLE;
            end else begin
              hold_rem <= hold_rem - HOLD_W'(1);
            end
          end
        end
        S_DATA: begin
          pend <= pend || i_branch_met;
          if (i_mem_ready) begin
            if (last) begin
              idx <= '0;
              // A branch seen during the transfers redirects before any hold time.
              if (pend || i_branch_met) begin
                state <= S_BR;
              end else if (HOLD_EN) begin
                state    <= S_HOLD;
                hold_rem <= HOLD_INIT;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_BR: begin
          state <= S_IDLE;
          pend  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
